// File: rtl/mux2.sv
// 2:1 word multiplexer with a combinational output, a registered copy with valid flag,
// and a saturating counter of select toggles for debug/coverage.
module mux2 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             control,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    output logic [WIDTH-1:0] ou,
    output logic [WIDTH-1:0] ou_q,
    output logic             out_valid,
    output logic             sel_q,
    output logic [CNT_W-1:0] sw_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic prev_ctl;

    // Zero-latency path stays live through reset so the datapath never stalls on it.
    assign ou = control ? B : A;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ou_q      <= '0;
            sel_q     <= 1'b0;
            out_valid <= 1'b0;
            sw_cnt    <= '0;
            prev_ctl  <= 1'b0;
        end else begin
            if (in_valid) begin
                ou_q      <= ou;
                sel_q     <= control;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
            prev_ctl <= control;
            // Saturate rather than wrap so a long run never reads back as zero toggles.
            if ((control != prev_ctl) && (sw_cnt != CNT_MAX))
                sw_cnt <= sw_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mux2.sv
// Self-checking bench for mux2: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_mux2;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             control;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             in_valid;
    logic [WIDTH-1:0] ou;
    logic [WIDTH-1:0] ou_q;
    logic             out_valid;
    logic             sel_q;
    logic [CNT_W-1:0] sw_cnt;

    int vectors;
    int miscompares;

    // Reference model state, advanced once per rising clock.
    logic [WIDTH-1:0] exp_q;
    logic             exp_sel;
    logic             exp_valid;
    int               exp_cnt;
    logic             last_ctl;

    mux2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .control(control),
        .A(A),
        .B(B),
        .in_valid(in_valid),
        .ou(ou),
        .ou_q(ou_q),
        .out_valid(out_valid),
        .sel_q(sel_q),
        .sw_cnt(sw_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, check the mux immediately, then check the registered
    // outputs just after the clock edge against the model.
    task automatic applyStimulus(input logic rst_v, input logic ctl, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic v);
        rst_n    = rst_v;
        control  = ctl;
        A        = a;
        B        = b;
        in_valid = v;
        #1;
        checkOutput("ou", ou, ctl ? b : a);
        @(posedge clk);
        if (!rst_v) begin
            exp_q     = '0;
            exp_sel   = 1'b0;
            exp_valid = 1'b0;
            exp_cnt   = 0;
            last_ctl  = 1'b0;
        end else begin
            if (v) begin
                exp_q     = ctl ? b : a;
                exp_sel   = ctl;
                exp_valid = 1'b1;
            end else begin
                exp_valid = 1'b0;
            end
            if (ctl != last_ctl && exp_cnt < CNT_MAX) exp_cnt = exp_cnt + 1;
            last_ctl = ctl;
        end
        #1;
        checkOutput("ou_q", ou_q, exp_q);
        checkOutput("out_valid", WIDTH'(out_valid), WIDTH'(exp_valid));
        checkOutput("sel_q", WIDTH'(sel_q), WIDTH'(exp_sel));
        checkOutput("sw_cnt", WIDTH'(sw_cnt), WIDTH'(exp_cnt));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_q = '0; exp_sel = 1'b0; exp_valid = 1'b0; exp_cnt = 0; last_ctl = 1'b0;
        @(negedge clk);

        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h5, 32'h6, 1'b1);

        // Basic select and one-cycle registered latency.
        applyStimulus(1'b1, 1'b0, 32'h1, 32'h2, 1'b1);
        checkOutput("t1_ou_q", ou_q, 32'h1);
        applyStimulus(1'b1, 1'b1, 32'h1, 32'h2, 1'b1);
        checkOutput("t2_ou_q", ou_q, 32'h2);
        checkOutput("t2_cnt", WIDTH'(sw_cnt), 32'd1);

        // Back-to-back captures, then hold.
        applyStimulus(1'b1, 1'b0, 32'd10, 32'd99, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'd20, 32'd99, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'd30, 32'd99, 1'b1);
        checkOutput("t3_ou_q", ou_q, 32'd30);
        applyStimulus(1'b1, 1'b0, 32'd40, 32'd99, 1'b0);
        checkOutput("t3_hold", ou_q, 32'd30);
        checkOutput("t3_valid", WIDTH'(out_valid), 32'd0);

        // Reset beats in_valid; mux output keeps tracking.
        applyStimulus(1'b1, 1'b1, 32'hAA, 32'hBB, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'hCC, 32'hDD, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'hCC, 32'hDD, 1'b1);
        checkOutput("t4_cnt", WIDTH'(sw_cnt), 32'd0);
        checkOutput("t4_ou_q", ou_q, 32'd0);

        // Full-width values pass bit-exact.
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, i[0], 32'hFFFF_FFFF, 32'h0, 1'b1);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 400; i++)
            applyStimulus(($urandom_range(0, 31) != 0), 1'($urandom), $urandom, $urandom,
                          1'($urandom));

        // Saturation: toggle past the counter range and confirm it pins at all-ones.
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < (1 << CNT_W) + 5; i++)
            applyStimulus(1'b1, ~i[0], 32'h1234, 32'h5678, 1'b0);
        checkOutput("t5_sat", WIDTH'(sw_cnt), WIDTH'(CNT_MAX));
        applyStimulus(1'b1, 1'b0, 32'h1, 32'h2, 1'b1);
        checkOutput("t5_nowrap", WIDTH'(sw_cnt), WIDTH'(CNT_MAX));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
